// File: rtl/fifo_flagged.sv
// rtl/fifo_flagged.sv - synchronous FIFO with count, threshold flags, error pulses and selectable read mode
module fifo_flagged #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           enq_in,
  input  logic [DATA_WIDTH-1:0]          enq_data_in,
  input  logic                           deq_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  output logic                           full_out,
  output logic                           empty_out,
  output logic                           almost_full_out,
  output logic                           almost_empty_out,
  output logic [$clog2(DEPTH+1)-1:0]     count_out,
  output logic                           overflow_out,
  output logic                           underflow_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  enq_ok;
  logic                  deq_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags come from the count register only, never from this cycle's requests.
  assign full_out         = (count == CW'(DEPTH));
  assign empty_out        = (count == '0);
  assign almost_full_out  = (count >= CW'(AF_THRESH));
  assign almost_empty_out = (count <= CW'(AE_THRESH));
  assign count_out        = count;

  // No bypass: a full FIFO refuses writes and an empty one refuses reads,
  // regardless of what the other side does in the same cycle.
  assign enq_ok = enq_in && !full_out;
  assign deq_ok = deq_in && !empty_out;

  // Pointer, occupancy and error-pulse state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      overflow_out  <= enq_in && full_out;
      underflow_out <= deq_in && empty_out;
      if (enq_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (deq_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq_ok, deq_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset so it is not cleared.
  always_ff @(posedge clk_in) begin
    if (!rst_in && enq_ok) mem[wr_ptr] <= enq_data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out  = mem[rd_ptr];
      assign valid_out = !empty_out;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  rd_valid;

      // Registered read: capture the head on an accepted pop, hold it otherwise.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= deq_ok;
          if (deq_ok) rd_data <= mem[rd_ptr];
        end
      end

      assign data_out  = rd_data;
      assign valid_out = rd_valid;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flagged.sv
// tb/tb_fifo_flagged.sv - self-checking bench for fifo_flagged in registered and FWFT modes
module tb_fifo_flagged;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Registered-read instance: DEPTH=5, AF_THRESH=4, AE_THRESH=1
  logic       r0, e0, q0;
  logic [7:0] d0, do0;
  logic       v0, f0, em0, af0, ae0, ov0, un0;
  logic [2:0] c0;

  fifo_flagged #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_dut0 (
    .clk_in(clk_in), .rst_in(r0), .enq_in(e0), .enq_data_in(d0), .deq_in(q0),
    .data_out(do0), .valid_out(v0), .full_out(f0), .empty_out(em0),
    .almost_full_out(af0), .almost_empty_out(ae0), .count_out(c0),
    .overflow_out(ov0), .underflow_out(un0)
  );

  // FWFT instance: DEPTH=8, default thresholds (AF=6, AE=1)
  logic       r1, e1, q1;
  logic [7:0] d1, do1;
  logic       v1, f1, em1, af1, ae1, ov1, un1;
  logic [3:0] c1;

  fifo_flagged #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) u_dut1 (
    .clk_in(clk_in), .rst_in(r1), .enq_in(e1), .enq_data_in(d1), .deq_in(q1),
    .data_out(do1), .valid_out(v1), .full_out(f1), .empty_out(em1),
    .almost_full_out(af1), .almost_empty_out(ae1), .count_out(c1),
    .overflow_out(ov1), .underflow_out(un1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural queue model for instance 0 and a scoreboard of expected reads.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       last_acc_d, last_rej_e, last_rej_d;

  task automatic step0(input logic r, input logic e, input logic q, input logic [7:0] d);
    int  sz;
    logic acc_e, acc_d;
    r0 = r; e0 = e; q0 = q; d0 = d;
    @(posedge clk_in);
    #1;
    sz = mq.size();
    if (r) begin
      mq.delete();
      exp_q.delete();
      last_acc_d = 0; last_rej_e = 0; last_rej_d = 0;
    end else begin
      acc_e = e && (sz < 5);
      acc_d = q && (sz > 0);
      last_acc_d = acc_d;
      last_rej_e = e && !acc_e;
      last_rej_d = q && !acc_d;
      if (acc_d) exp_q.push_back(mq.pop_front());
      if (acc_e) mq.push_back(d);
    end
    if (v0 === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
      else chk("sb_data", do0, exp_q.pop_front());
    end
  endtask

  task automatic chk_model0(input string tag);
    chk({tag, "_count"}, c0, mq.size());
    chk({tag, "_full"},  f0, (mq.size() == 5));
    chk({tag, "_empty"}, em0, (mq.size() == 0));
    chk({tag, "_valid"}, v0, last_acc_d);
    chk({tag, "_ovf"},   ov0, last_rej_e);
    chk({tag, "_unf"},   un0, last_rej_d);
  endtask

  task automatic step1(input logic r, input logic e, input logic q, input logic [7:0] d);
    r1 = r; e1 = e; q1 = q; d1 = d;
    @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    logic       rst, enq, deq;
    logic [7:0] d;
    int         cnt;
    logic       full, empty, af, ae, ovf, unf, vld;
  } vec_t;

  vec_t tbl[15];

  initial begin
    r0 = 1; e0 = 0; q0 = 0; d0 = 0;
    r1 = 1; e1 = 0; q1 = 0; d1 = 0;
    last_acc_d = 0; last_rej_e = 0; last_rej_d = 0;

    //          rst enq deq data  cnt full empty af ae ovf unf vld
    tbl[0]  = '{1, 0, 0, 8'd0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 8'd1, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 8'd2, 2, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 8'd3, 3, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 8'd4, 4, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 8'd5, 5, 1, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 8'd6, 5, 1, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 8'd0, 5, 1, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 8'd0, 4, 0, 0, 1, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 1, 8'd0, 3, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 1, 8'd0, 2, 0, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 1, 8'd0, 1, 0, 0, 0, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 1, 8'd0, 0, 0, 1, 0, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 1, 8'd0, 0, 0, 1, 0, 1, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 8'd0, 0, 0, 1, 0, 1, 0, 0, 0};

    // Fill past full, drain past empty (registered-read instance)
    for (int i = 0; i < 15; i++) begin
      step0(tbl[i].rst, tbl[i].enq, tbl[i].deq, tbl[i].d);
      chk($sformatf("t%0d_count", i), c0, tbl[i].cnt);
      chk($sformatf("t%0d_full", i),  f0, tbl[i].full);
      chk($sformatf("t%0d_empty", i), em0, tbl[i].empty);
      chk($sformatf("t%0d_af", i),    af0, tbl[i].af);
      chk($sformatf("t%0d_ae", i),    ae0, tbl[i].ae);
      chk($sformatf("t%0d_ovf", i),   ov0, tbl[i].ovf);
      chk($sformatf("t%0d_unf", i),   un0, tbl[i].unf);
      chk($sformatf("t%0d_valid", i), v0, tbl[i].vld);
      if (i == 0) chk("rst_data", do0, 0);
    end
    chk("data_hold", do0, 5);

    // Simultaneous enq+deq at count=3
    for (int i = 0; i < 3; i++) step0(0, 1, 0, 8'h20 + 8'(i));
    step0(0, 1, 1, 8'h23);
    chk_model0("both_at3");
    chk("both_at3_cnt3", c0, 3);

    // Simultaneous enq+deq at full
    step0(0, 1, 0, 8'h24);
    step0(0, 1, 0, 8'h25);
    chk("fill_full", f0, 1);
    step0(0, 1, 1, 8'h26);
    chk_model0("both_full");
    chk("both_full_cnt4", c0, 4);
    chk("both_full_ovf", ov0, 1);

    // Drain, then simultaneous enq+deq at empty
    for (int i = 0; i < 4; i++) step0(0, 0, 1, 8'h00);
    chk("drained", em0, 1);
    step0(0, 1, 1, 8'h30);
    chk_model0("both_empty");
    chk("both_empty_cnt1", c0, 1);
    chk("both_empty_unf", un0, 1);
    step0(0, 0, 1, 8'h00);
    chk_model0("pop_30");

    // Interleaved traffic at occupancy 2..3, wrapping pointers repeatedly
    step0(0, 1, 0, 8'h40);
    step0(0, 1, 0, 8'h41);
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       step0(0, 1, 0, 8'h50 + 8'(i));
        1:       step0(0, 1, 1, 8'h50 + 8'(i));
        default: step0(0, 0, 1, 8'h00);
      endcase
      chk($sformatf("wrap%0d_range", i), (c0 >= 3'd2 && c0 <= 3'd3), 1);
      chk_model0($sformatf("wrap%0d", i));
    end
    while (mq.size() > 0) step0(0, 0, 1, 8'h00);
    step0(0, 0, 0, 8'h00);
    chk("sb_drained", exp_q.size(), 0);

    // FWFT instance
    step1(1, 0, 0, 8'h00);
    chk("f_rst_valid", v1, 0);
    chk("f_rst_empty", em1, 1);
    chk("f_rst_count", c1, 0);
    chk("f_rst_ae", ae1, 1);
    chk("f_rst_af", af1, 0);
    step1(0, 1, 0, 8'hA5);
    chk("f_a5_valid", v1, 1);
    chk("f_a5_data", do1, 8'hA5);
    chk("f_a5_count", c1, 1);
    step1(0, 0, 1, 8'h00);
    chk("f_pop_valid", v1, 0);
    chk("f_pop_empty", em1, 1);
    for (int i = 0; i < 6; i++) begin
      step1(0, 1, 0, 8'h10 + 8'(i));
      chk($sformatf("f_fill%0d_head", i), do1, 8'h10);
      chk($sformatf("f_fill%0d_count", i), c1, i + 1);
    end
    chk("f_six_af", af1, 1);
    chk("f_six_ae", ae1, 0);
    step1(0, 0, 1, 8'h00);
    chk("f_next_head", do1, 8'h11);
    step1(0, 1, 0, 8'h16);
    chk("f_refill_count", c1, 6);

    // Reset mid-stream with both requests high
    step1(1, 1, 1, 8'hFF);
    chk("f_mrst_count", c1, 0);
    chk("f_mrst_empty", em1, 1);
    chk("f_mrst_valid", v1, 0);
    chk("f_mrst_ovf", ov1, 0);
    chk("f_mrst_unf", un1, 0);
    step1(0, 0, 0, 8'h00);
    chk("f_post_ovf", ov1, 0);
    chk("f_post_unf", un1, 0);
    chk("f_post_count", c1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
